// File: rtl/dmrfalu_ctrl.sv
// Multicycle control FSM for the data-memory / register-file / ALU datapath.
// Steps one instruction at a time through decode, execute, memory and write-back.
module dmrfalu_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [5:0]       FuncCode,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             branch_taken,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_I      = 4'd5,
    S_EXEC_ADDR = 4'd6,
    S_MEM_RD    = 4'd7,
    S_MEM_WR    = 4'd8,
    S_WB_MEM    = 4'd9,
    S_EXEC_BR   = 4'd10,
    S_DONE      = 4'd11,
    S_ERR       = 4'd12
  } state_t;

  typedef struct packed {
    logic       instr_ready;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       done;
    logic       err;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{instr_ready: 1'b1, alu_op: 2'b00, alu_src: 1'b0,
                                 reg_dst: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0,
                                 mem_write: 1'b0, reg_write: 1'b0, done: 1'b0, err: 1'b0};

  // Strobe pattern of each state; registered against the next state so outputs
  // change exactly when the state register does.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE:      c.instr_ready = 1'b1;
      S_DECODE:    c.alu_op      = 2'b00;
      S_EXEC_R:    c.alu_op      = 2'b10;
      S_WB_R:      begin c.alu_op = 2'b10; c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_EXEC_I:    begin c.alu_op = 2'b00; c.alu_src = 1'b1; end
      S_WB_I:      begin c.alu_op = 2'b00; c.alu_src = 1'b1; c.reg_write = 1'b1; end
      S_EXEC_ADDR: begin c.alu_op = 2'b00; c.alu_src = 1'b1; end
      S_MEM_RD:    begin c.alu_op = 2'b00; c.alu_src = 1'b1; c.mem_read = 1'b1; end
      S_MEM_WR:    begin c.alu_op = 2'b00; c.alu_src = 1'b1; c.mem_write = 1'b1; end
      S_WB_MEM:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_EXEC_BR:   c.alu_op      = 2'b01;
      S_DONE:      c.done        = 1'b1;
      S_ERR:       c.err         = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  ctrl_t              ctrl_q;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [5:0]         op_q;
  logic [5:0]         func_q;
  logic               bt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept_s;

  assign accept_s = (state_q == S_IDLE) && instr_valid;

  // Next-state and memory wait counter; completion beats timeout in the last wait cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) state_d = S_DECODE;
        else             state_d = S_IDLE;
      end
      S_DECODE: begin
        case (op_q)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_EXEC_ADDR;
          OP_BEQ:        state_d = S_EXEC_BR;
          OP_ADDI:       state_d = S_EXEC_I;
          default:       state_d = S_ERR;
        endcase
      end
      S_EXEC_R:    state_d = S_WB_R;
      S_WB_R:      state_d = S_DONE;
      S_EXEC_I:    state_d = S_WB_I;
      S_WB_I:      state_d = S_DONE;
      S_EXEC_ADDR: begin
        wait_d = {WAIT_W{1'b0}};
        if (op_q == OP_LW) state_d = S_MEM_RD;
        else               state_d = S_MEM_WR;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          if (state_q == S_MEM_RD) state_d = S_WB_MEM;
          else                     state_d = S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB_MEM:    state_d = S_DONE;
      S_EXEC_BR:   state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      S_ERR:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State, registered strobes, captured fields and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= CTRL_RST;
      wait_q  <= {WAIT_W{1'b0}};
      op_q    <= 6'h00;
      func_q  <= 6'h00;
      bt_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
      wait_q  <= wait_d;
      if (accept_s) begin
        op_q   <= opcode;
        func_q <= funct;
        bt_q   <= 1'b0;
      end else if (state_q == S_EXEC_BR) begin
        bt_q   <= zero;
      end
      if (state_d == S_DONE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_ready   = ctrl_q.instr_ready;
  assign ALUOp         = ctrl_q.alu_op;
  assign ALUSrc        = ctrl_q.alu_src;
  assign RegDst        = ctrl_q.reg_dst;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign MemRead       = ctrl_q.mem_read;
  assign MemWrite      = ctrl_q.mem_write;
  assign RegWrite      = ctrl_q.reg_write;
  assign done          = ctrl_q.done;
  assign err           = ctrl_q.err;
  assign FuncCode      = func_q;
  assign branch_taken  = bt_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_dmrfalu_ctrl.sv
// Scoreboard bench for dmrfalu_ctrl: directed instructions push expected
// completion records; a monitor profiles each instruction and compares on done/err.
module tb_dmrfalu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic [5:0]  FuncCode;
  logic [1:0]  ALUOp;
  logic        ALUSrc, RegDst, MemtoReg, MemRead, MemWrite, RegWrite;
  logic        branch_taken, done, err;
  logic [15:0] retired_count;

  dmrfalu_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .FuncCode(FuncCode), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .branch_taken(branch_taken), .done(done), .err(err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    int          cyc;
    int          n_rd, n_wr, n_rw, n_m2r, n_dst, n_any;
    logic [1:0]  alu_c2;
    logic [5:0]  fc;
    logic        bt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic is_err, input int cyc, input int n_rd, input int n_wr,
                              input int n_rw, input int n_m2r, input int n_dst, input int n_any,
                              input logic [1:0] alu_c2, input logic [5:0] fc, input logic bt,
                              input logic [15:0] cnt);
    exp_t e;
    e.is_err = is_err; e.cyc = cyc; e.n_rd = n_rd; e.n_wr = n_wr; e.n_rw = n_rw;
    e.n_m2r = n_m2r; e.n_dst = n_dst; e.n_any = n_any; e.alu_c2 = alu_c2;
    e.fc = fc; e.bt = bt; e.cnt = cnt;
    return e;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_FuncCode", 32'(FuncCode), 32'd0);
    chk("rst_ALUOp", 32'(ALUOp), 32'd0);
    chk("rst_ALUSrc", 32'(ALUSrc), 32'd0);
    chk("rst_RegDst", 32'(RegDst), 32'd0);
    chk("rst_MemtoReg", 32'(MemtoReg), 32'd0);
    chk("rst_MemRead", 32'(MemRead), 32'd0);
    chk("rst_MemWrite", 32'(MemWrite), 32'd0);
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_branch_taken", 32'(branch_taken), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retired_count", 32'(retired_count), 32'd0);
  endtask

  // ready_at: cycle in which mem_ready rises (0 = high from the start, 255 = never).
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int ready_at,
                       input logic z, input exp_t e);
    mem_ready = (ready_at == 0);
    zero      = z;
    for (int i = 0; i < 50 && !instr_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_before_issue", 32'(instr_ready), 32'd1);
    sb_q.push_back(e);
    instr_valid = 1'b1;
    opcode      = op;
    funct       = fn;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opcode      = 6'h15;
    funct       = 6'h2E;
    for (int k = 1; k <= e.cyc; k++) begin
      if (k == ready_at) mem_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Monitor: profiles the in-flight instruction and compares at done/err.
  initial begin
    logic        active = 1'b0;
    logic        post   = 1'b0;
    logic [15:0] post_cnt = 16'd0;
    int          cyc = 0;
    int          n_rd = 0, n_wr = 0, n_rw = 0, n_m2r = 0, n_dst = 0, n_any = 0;
    logic [1:0]  alu_c2 = 2'b00;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        post   = 1'b0;
      end else begin
        chk("rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
        chk("regwrite_in_mem", 32'(RegWrite & (MemRead | MemWrite)), 32'd0);
        if (post) begin
          post = 1'b0;
          chk("idle_after_end", 32'(instr_ready), 32'd1);
          chk("retired_count", 32'(retired_count), 32'(post_cnt));
        end
        if (active) begin
          cyc++;
          if (MemRead)  n_rd++;
          if (MemWrite) n_wr++;
          if (RegWrite) n_rw++;
          if (MemtoReg) n_m2r++;
          if (RegDst)   n_dst++;
          if ((ALUOp != 2'b00) || ALUSrc || RegDst || MemtoReg || MemRead || MemWrite || RegWrite)
            n_any++;
          if (cyc == 2) alu_c2 = ALUOp;
          if (done || err) begin
            active = 1'b0;
            if (sb_q.size() == 0) begin
              chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
              e = sb_q.pop_front();
              chk("end_kind_err", 32'(err), 32'(e.is_err));
              chk("end_kind_done", 32'(done), 32'(!e.is_err));
              chk("end_cycle", 32'(cyc), 32'(e.cyc));
              chk("memread_cycles", 32'(n_rd), 32'(e.n_rd));
              chk("memwrite_cycles", 32'(n_wr), 32'(e.n_wr));
              chk("regwrite_cycles", 32'(n_rw), 32'(e.n_rw));
              chk("memtoreg_cycles", 32'(n_m2r), 32'(e.n_m2r));
              chk("regdst_cycles", 32'(n_dst), 32'(e.n_dst));
              chk("strobe_cycles", 32'(n_any), 32'(e.n_any));
              chk("aluop_cycle2", 32'(alu_c2), 32'(e.alu_c2));
              chk("FuncCode", 32'(FuncCode), 32'(e.fc));
              chk("branch_taken", 32'(branch_taken), 32'(e.bt));
              post     = 1'b1;
              post_cnt = e.cnt;
            end
          end else if (cyc > 200) begin
            chk("completion_timeout", 32'd1, 32'd0);
            active = 1'b0;
          end
        end else if (done || err) begin
          chk("stray_completion", 32'd1, 32'd0);
        end
        if (instr_valid && instr_ready) begin
          active = 1'b1;
          cyc = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_m2r = 0; n_dst = 0; n_any = 0;
          alu_c2 = 2'b00;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stimulus: directed instructions with hand-computed completion records.
  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; opcode = 6'h00; funct = 6'h00;
    zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    //        err  cyc rd wr rw m2r dst any alu2  fc     bt cnt
    issue(6'h00, 6'h20, 0, 1'b0,   mk(1'b0, 4, 0, 0, 1, 0, 1, 2, 2'b10, 6'h20, 1'b0, 16'd1));
    issue(6'h23, 6'h11, 6, 1'b0,   mk(1'b0, 8, 4, 0, 1, 1, 0, 6, 2'b00, 6'h11, 1'b0, 16'd2));
    issue(6'h2B, 6'h05, 255, 1'b0, mk(1'b1, 18, 0, 15, 0, 0, 0, 16, 2'b00, 6'h05, 1'b0, 16'd2));
    issue(6'h04, 6'h00, 0, 1'b1,   mk(1'b0, 3, 0, 0, 0, 0, 0, 1, 2'b01, 6'h00, 1'b1, 16'd3));
    issue(6'h04, 6'h01, 0, 1'b0,   mk(1'b0, 3, 0, 0, 0, 0, 0, 1, 2'b01, 6'h01, 1'b0, 16'd4));
    issue(6'h08, 6'h2A, 0, 1'b0,   mk(1'b0, 4, 0, 0, 1, 0, 0, 2, 2'b00, 6'h2A, 1'b0, 16'd5));
    issue(6'h3F, 6'h3F, 0, 1'b1,   mk(1'b1, 2, 0, 0, 0, 0, 0, 0, 2'b00, 6'h3F, 1'b0, 16'd5));
    issue(6'h2B, 6'h07, 0, 1'b0,   mk(1'b0, 4, 0, 1, 0, 0, 0, 2, 2'b00, 6'h07, 1'b0, 16'd6));
    issue(6'h23, 6'h09, 17, 1'b0,  mk(1'b0, 19, 15, 0, 1, 1, 0, 17, 2'b00, 6'h09, 1'b0, 16'd7));

    // lw interrupted by reset while waiting in MEM_RD
    @(posedge clk); #1;
    mem_ready = 1'b0;
    instr_valid = 1'b1; opcode = 6'h23; funct = 6'h33;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("memread_before_reset", 32'(MemRead), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(6'h23, 6'h12, 0, 1'b0,   mk(1'b0, 5, 1, 0, 1, 1, 0, 3, 2'b00, 6'h12, 1'b0, 16'd1));

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmrfalu_ctrl.md
# dmrfalu_ctrl

Multicycle control FSM that sequences the data-memory / register-file / ALU datapath one instruction at a time. It accepts a decoded opcode/funct pair over a valid/ready handshake and steps through decode, execute, memory and write-back states. In each state it drives the datapath strobes (MemRead, MemWrite, RegWrite, ALUOp, mux selects). It sits between the instruction source and the datapath top level, and reports completion, errors and a retired-instruction count.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive MEM_RD/MEM_WR cycles without mem_ready before abort (≥1).
- CNT_W, 16: width of retired_count.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  opcode/funct valid
- instr_ready  out  1  controller idle, can accept
- opcode  in  6  instruction opcode, sampled on accept
- funct  in  6  R-type function field, sampled on accept
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory completed current access
- FuncCode  out  6  captured funct, held until next accept
- ALUOp  out  2  00 add, 01 subtract, 10 decode FuncCode
- ALUSrc  out  1  0 = ReadData2, 1 = sign-extended immediate
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALU result, 1 = memory read data
- MemRead, MemWrite, RegWrite  out  1 each  datapath strobes
- branch_taken  out  1  beq outcome, held until next accept
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on illegal opcode or memory timeout
- retired_count  out  CNT_W  instructions completed through DONE

## Operation
- All control outputs decode from the state register only; there is no combinational path from an input to an output.
- Outputs not listed for a state are 0.
- IDLE: instr_ready=1. When instr_valid=1, capture opcode/funct and go to DECODE.
- DECODE: classify the captured opcode:
  - 0x00 → EXEC_R
  - 0x23 (lw) / 0x2B (sw) → EXEC_ADDR
  - 0x04 (beq) → EXEC_BR
  - 0x08 (addi) → EXEC_I
  - any other value → ERR
- EXEC_R: ALUOp=10, ALUSrc=0 → WB_R.
- WB_R: ALUOp=10, RegDst=1, RegWrite=1 → DONE.
- EXEC_I: ALUOp=00, ALUSrc=1 → WB_I.
- WB_I: ALUOp=00, ALUSrc=1, RegWrite=1 → DONE.
- EXEC_ADDR: ALUOp=00, ALUSrc=1 → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: ALUOp=00, ALUSrc=1, MemRead=1. Stay until mem_ready=1, then go to WB_MEM.
- MEM_WR: ALUOp=00, ALUSrc=1, MemWrite=1. Stay until mem_ready=1, then go to DONE.
- WB_MEM: MemtoReg=1, RegWrite=1 → DONE.
- EXEC_BR: ALUOp=01, ALUSrc=0. Register zero into branch_taken → DONE.
- DONE: done=1, retired_count increments → IDLE.
- ERR: err=1, retired_count unchanged → IDLE.
- Memory wait counter:
  - Clears on entry to MEM_RD/MEM_WR.
  - Increments each MEM_* cycle in which mem_ready=0.
  - When mem_ready=0 in the MEM_TIMEOUT-th consecutive cycle, go to ERR. The strobe drops when ERR is entered.
  - mem_ready=1 in that same cycle completes normally; completion has priority over timeout.
- retired_count wraps modulo 2^CNT_W.
- FuncCode is held from accept until the next accept.
- branch_taken is cleared on accept of every instruction and is set only in EXEC_BR.

## Timing
- Reset value of every output is 0 except instr_ready, which is 1 (state IDLE).
- Reset clears the captured fields, branch_taken, the wait counter and retired_count.
- Reset asserted mid-instruction forces IDLE immediately (asynchronous) and all strobes drop with no completion.
- Cycle numbering: the accept edge is the clk edge where instr_valid & instr_ready = 1. Cycle N is the Nth cycle after that edge.
- done occurs in cycle:
  - 4 for R-type, addi and sw (sw with zero wait)
  - 5 for lw (zero wait)
  - 3 for beq
- Each wait cycle in MEM_* adds 1 to the done cycle.
- Illegal opcode: err in cycle 2; instr_ready=1 in cycle 3.
- instr_ready=0 from cycle 1 until the return to IDLE. instr_valid is ignored while busy.
- Back-to-back instructions: the next accept edge can be the edge that ends the first IDLE cycle after DONE/ERR. The minimum issue interval equals latency + 1.
- Strobes are constant throughout a state. MemRead/MemWrite are never both 1. RegWrite is never 1 in a MEM_* state.

## Test plan
- Reset, then R-type accept with opcode=0x00, funct=0x20:
  - cycle 2: ALUOp=10
  - cycle 3: RegWrite=1, RegDst=1
  - cycle 4: done=1
  - FuncCode=0x20; retired_count=1.
- lw (0x23) with mem_ready held low 3 cycles, then high:
  - MemRead=1 for exactly 4 cycles
  - WB_MEM: MemtoReg=1, RegWrite=1
  - done in cycle 8
- sw (0x2B) with mem_ready low forever, MEM_TIMEOUT=15:
  - MemWrite=1 for 15 cycles, then err pulse
  - no done; retired_count unchanged
- Run beq (0x04) twice, once with zero=1 and once with zero=0 in EXEC_BR:
  - zero=1: branch_taken=1, done in cycle 3
  - zero=0: branch_taken=0
- Illegal opcode 0x3F: err in cycle 2; no strobes at any point; IDLE in cycle 3.
- rst_n pulsed low during MEM_RD: MemRead drops asynchronously, all outputs return to reset values, and the next lw completes normally.
